// File: rtl/conv_tile_sched.sv
// conv_tile_sched: holds one 4x4 fp16 ifmap tile plus a 3x3 kernel, streams the tile into the conv engine
// Latency: go -> first eng_start 1 cycle; done pulses 1 cycle after all results + eng_done (or wait timeout)
// Backpressure: none; buffer writes while busy are dropped and flagged in wr_err, go while busy is ignored
//
// Ports: host write path (if_we/if_waddr, wg_we/wg_waddr, wdata), control (go, busy, done, wr_err, tmo_err),
//   ofmap read (of_raddr -> of_rdata, combinational), engine side (eng_start, eng_din, eng_weight,
//   eng_result, eng_dout_valid, eng_done). rst_n is a synchronous active-low reset that clears all state.
// Build option: define CONV_SCHED_RELU_EN to store any result with its sign bit set as 0 (ReLU).

module conv_tile_sched #(
    parameter int DW      = 16,
    parameter int IF_N    = 16,
    parameter int WG_N    = 9,
    parameter int OF_N    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_we,
    input  logic [3:0]         if_waddr,
    input  logic               wg_we,
    input  logic [3:0]         wg_waddr,
    input  logic [DW-1:0]      wdata,
    input  logic               go,
    input  logic [1:0]         of_raddr,
    output logic [DW-1:0]      of_rdata,
    output logic               busy,
    output logic               done,
    output logic               wr_err,
    output logic               tmo_err,
    output logic               eng_start,
    output logic [DW-1:0]      eng_din,
    output logic [WG_N*DW-1:0] eng_weight,
    input  logic [DW-1:0]      eng_result,
    input  logic               eng_dout_valid,
    input  logic               eng_done
);

    localparam int IW  = $clog2(IF_N);
    localparam int OW  = $clog2(OF_N + 1);
    localparam int OAW = $clog2(OF_N);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_OUT,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic            eng_start_q;
    logic            wr_err_q;
    logic            tmo_err_q;
    logic            seen_done_q;
    logic [IW-1:0]   in_cnt_q;
    logic [OW-1:0]   out_cnt_q;
    logic [TW-1:0]   wait_cnt_q;

    logic [DW-1:0]   ifmap_q [IF_N];
    logic [DW-1:0]   wg_q    [WG_N];
    logic [DW-1:0]   ofmap_q [OF_N];

    logic            idle;
    logic            go_acc;
    logic            capture_en;
    logic            cap_fire;
    logic [DW-1:0]   result_d;
    logic [OW-1:0]   out_cnt_d;
    logic            seen_done_d;
    logic            all_in;
    logic            tmo_hit;

    assign idle       = (state_q == S_IDLE);
    assign go_acc     = go && idle;
    assign capture_en = (state_q == S_STREAM) || (state_q == S_WAIT_OUT);
    // Valids beyond the fourth result are dropped, not wrapped.
    assign cap_fire   = capture_en && eng_dout_valid && (out_cnt_q < OW'(OF_N));

`ifdef CONV_SCHED_RELU_EN
    // Sign bit alone decides, so -0 and negative NaN also clamp to +0.
    assign result_d = eng_result[DW-1] ? '0 : eng_result;
`else
    assign result_d = eng_result;
`endif

    // Completion looks at this cycle's capture/eng_done too, so a last valid and
    // eng_done arriving together still reach DONE on the very next cycle.
    assign out_cnt_d   = out_cnt_q + OW'(cap_fire);
    assign seen_done_d = seen_done_q || (capture_en && eng_done);
    assign all_in      = (out_cnt_d == OW'(OF_N)) && seen_done_d;
    assign tmo_hit     = (wait_cnt_q == TW'(TIMEOUT));

    assign busy      = busy_q;
    assign done      = done_q;
    assign eng_start = eng_start_q;
    assign wr_err    = wr_err_q;
    assign tmo_err   = tmo_err_q;
    assign of_rdata  = ofmap_q[of_raddr];
    assign eng_din   = (state_q == S_STREAM) ? ifmap_q[in_cnt_q] : '0;

    // Weights can only change in IDLE, so the kernel is stable for the whole tile.
    always_comb begin
        eng_weight = '0;
        for (int i = 0; i < WG_N; i++) begin
            eng_weight[i*DW +: DW] = wg_q[i];
        end
    end

    // Tile buffers: host writes only in IDLE (including the go cycle itself).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < IF_N; i++) ifmap_q[i] <= '0;
            for (int i = 0; i < WG_N; i++) wg_q[i] <= '0;
            for (int i = 0; i < OF_N; i++) ofmap_q[i] <= '0;
        end else begin
            if (idle) begin
                for (int i = 0; i < IF_N; i++) begin
                    if (if_we && (if_waddr == 4'(i))) ifmap_q[i] <= wdata;
                end
                // Indices WG_N..15 match no entry and fall away.
                for (int i = 0; i < WG_N; i++) begin
                    if (wg_we && (wg_waddr == 4'(i))) wg_q[i] <= wdata;
                end
            end
            if (go_acc) begin
                for (int i = 0; i < OF_N; i++) ofmap_q[i] <= '0;
            end
            if (cap_fire) begin
                ofmap_q[out_cnt_q[OAW-1:0]] <= result_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eng_start_q <= 1'b0;
            wr_err_q    <= 1'b0;
            tmo_err_q   <= 1'b0;
            seen_done_q <= 1'b0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            wait_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (!idle && (if_we || wg_we)) begin
                wr_err_q <= 1'b1;
            end
            if (capture_en) begin
                out_cnt_q   <= out_cnt_d;
                seen_done_q <= seen_done_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_q     <= S_STREAM;
                        busy_q      <= 1'b1;
                        eng_start_q <= 1'b1;
                        wr_err_q    <= 1'b0;
                        tmo_err_q   <= 1'b0;
                        seen_done_q <= 1'b0;
                        in_cnt_q    <= '0;
                        out_cnt_q   <= '0;
                        wait_cnt_q  <= '0;
                    end
                end
                S_STREAM: begin
                    in_cnt_q <= in_cnt_q + IW'(1);
                    if (in_cnt_q == IW'(IF_N - 1)) begin
                        state_q <= S_WAIT_OUT;
                    end
                end
                S_WAIT_OUT: begin
                    // Normal completion wins over a timeout hitting in the same cycle.
                    if (all_in) begin
                        state_q     <= S_DONE;
                        eng_start_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q     <= S_DONE;
                        eng_start_q <= 1'b0;
                        done_q      <= 1'b1;
                        tmo_err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tile_sched.sv
`timescale 1ns/1ps
module tb_conv_tile_sched;

    localparam int TIMEOUT = 256;
    localparam int WAIT0   = 17;   // first WAIT_OUT cycle, counting the go cycle as 0
    localparam int MAXC    = 300;
`ifdef CONV_SCHED_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_we = 1'b0;
    logic [3:0]    if_waddr = '0;
    logic          wg_we = 1'b0;
    logic [3:0]    wg_waddr = '0;
    logic [15:0]   wdata = '0;
    logic          go = 1'b0;
    logic [1:0]    of_raddr = '0;
    logic [15:0]   of_rdata;
    logic          busy, done, wr_err, tmo_err, eng_start;
    logic [15:0]   eng_din;
    logic [143:0]  eng_weight;
    logic [15:0]   eng_result = '0;
    logic          eng_dout_valid = 1'b0;
    logic          eng_done = 1'b0;

    always #5 clk = ~clk;

    conv_tile_sched dut (
        .clk(clk), .rst_n(rst_n),
        .if_we(if_we), .if_waddr(if_waddr),
        .wg_we(wg_we), .wg_waddr(wg_waddr), .wdata(wdata),
        .go(go), .of_raddr(of_raddr), .of_rdata(of_rdata),
        .busy(busy), .done(done), .wr_err(wr_err), .tmo_err(tmo_err),
        .eng_start(eng_start), .eng_din(eng_din), .eng_weight(eng_weight),
        .eng_result(eng_result), .eng_dout_valid(eng_dout_valid), .eng_done(eng_done)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] ifm_m [16];
    logic [15:0] wg_m  [9];

    // Stub engine script, indexed by cycle after go (go cycle = 0).
    bit          s_vld  [MAXC];
    logic [15:0] s_val  [MAXC];
    bit          s_done [MAXC];

    int          busy_hit_cyc = -1;
    bit          go_wr = 1'b0;
    logic [3:0]  gw_addr = '0;
    logic [15:0] gw_data = '0;

    typedef struct {
        int               first;
        int               gap;
        int               n;
        int               done_cyc;
        logic [15:0]      base;
        int               exp_cc;
        bit               exp_tmo;
        logic [3:0][15:0] exp_of;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int first, input int gap, input int n, input int dc,
                                input logic [15:0] base, input int cc, input bit tmo,
                                input logic [15:0] o0, input logic [15:0] o1,
                                input logic [15:0] o2, input logic [15:0] o3);
        vec_t v;
        v.first = first; v.gap = gap; v.n = n; v.done_cyc = dc; v.base = base;
        v.exp_cc = cc; v.exp_tmo = tmo;
        v.exp_of[0] = o0; v.exp_of[1] = o1; v.exp_of[2] = o2; v.exp_of[3] = o3;
        return v;
    endfunction

    function automatic logic [15:0] relu16(input logic [15:0] v);
        if (RELU && v[15]) return 16'h0000;
        return v;
    endfunction

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            s_vld[c] = 1'b0; s_val[c] = '0; s_done[c] = 1'b0;
        end
    endtask

    task automatic load_vec(input vec_t v);
        clear_sched();
        for (int j = 0; j < v.n; j++) begin
            s_vld[v.first + j*v.gap] = 1'b1;
            s_val[v.first + j*v.gap] = v.base + 16'(j);
        end
        if (v.done_cyc > 0) s_done[v.done_cyc] = 1'b1;
    endtask

    // Reference: first cycle at or after WAIT_OUT entry where four results and an
    // eng_done have been seen; otherwise the wait limit. Results = first four valids.
    task automatic model(output int cc, output bit tmo, output logic [3:0][15:0] of);
        int nv = 0;
        bit sd = 1'b0;
        of = '0; cc = WAIT0 + TIMEOUT; tmo = 1'b1;
        for (int c = 1; c <= WAIT0 + TIMEOUT; c++) begin
            if (s_vld[c]) begin
                if (nv < 4) of[nv] = relu16(s_val[c]);
                nv++;
            end
            if (s_done[c]) sd = 1'b1;
            if (c >= WAIT0 && nv >= 4 && sd) begin
                cc = c; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic wr_if(input int a, input logic [15:0] d);
        if_we = 1'b1; if_waddr = 4'(a); wdata = d;
        @(posedge clk); #1;
        if_we = 1'b0;
    endtask

    task automatic wr_wg(input int a, input logic [15:0] d);
        wg_we = 1'b1; wg_waddr = 4'(a); wdata = d;
        @(posedge clk); #1;
        wg_we = 1'b0;
    endtask

    task automatic chk_of(input string tag, input logic [3:0][15:0] e);
        for (int j = 0; j < 4; j++) begin
            of_raddr = 2'(j);
            #1;
            chk($sformatf("%s ofmap[%0d]", tag, j), of_rdata, e[j]);
        end
    endtask

    task automatic chk_weights(input string tag);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s eng_weight[%0d]", tag, i), eng_weight[i*16 +: 16], wg_m[i]);
        end
    endtask

    // Runs one tile from go, driving the stub script and checking the per-cycle trace.
    task automatic run_tile(input string tag, input int exp_cc);
        int  mism = 0;
        int  first_bad = -1;
        int  dones = 0;
        int  done_at = -1;
        bit  eb, es, ed;
        logic [15:0] edin;
        for (int c = 0; c <= exp_cc + 2; c++) begin
            go       = (c == 0) || (c == busy_hit_cyc);
            if_we    = (c == 0 && go_wr) || (c == busy_hit_cyc);
            if_waddr = (c == busy_hit_cyc) ? 4'd3 : gw_addr;
            wdata    = (c == busy_hit_cyc) ? 16'h4000 : gw_data;
            eng_dout_valid = s_vld[c];
            eng_result     = s_val[c];
            eng_done       = s_done[c];
            #1;
            eb   = (c >= 1) && (c <= exp_cc + 1);
            es   = (c >= 1) && (c <= exp_cc);
            ed   = (c == exp_cc + 1);
            edin = (c >= 1 && c <= 16) ? ifm_m[c-1] : 16'h0000;
            if (busy !== eb || eng_start !== es || done !== ed || eng_din !== edin) begin
                mism++;
                if (first_bad < 0) first_bad = c;
            end
            if (done === 1'b1) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
            @(posedge clk); #1;
        end
        go = 1'b0; if_we = 1'b0; eng_dout_valid = 1'b0; eng_done = 1'b0; eng_result = '0;
        chk($sformatf("%s trace (first bad cycle %0d)", tag, first_bad), mism, 0);
        chk($sformatf("%s done cycle", tag), done_at, exp_cc + 1);
        chk($sformatf("%s done pulses", tag), dones, 1);
    endtask

    initial begin
        int cc;
        bit tmo;
        logic [3:0][15:0] of;
        bit exp_wr;

        vt[0] = mk(17, 1, 4, 20, 16'h4880, 20, 1'b0, 16'h4880, 16'h4881, 16'h4882, 16'h4883);
        vt[1] = mk(2, 2, 4, 5, 16'h0001, 17, 1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        vt[2] = mk(18, 1, 6, 21, 16'h0001, 21, 1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        vt[3] = mk(20, 1, 3, 25, 16'h1000, 273, 1'b1, 16'h1000, 16'h1001, 16'h1002, 16'h0000);
        vt[4] = mk(30, 10, 4, 10, 16'hC880, 60, 1'b0,
                   RELU ? 16'h0000 : 16'hC880, RELU ? 16'h0000 : 16'hC881,
                   RELU ? 16'h0000 : 16'hC882, RELU ? 16'h0000 : 16'hC883);
        vt[5] = mk(17, 1, 4, 40, 16'h7C00, 40, 1'b0, 16'h7C00, 16'h7C01, 16'h7C02, 16'h7C03);
        vt[6] = mk(1, 1, 0, 0, 16'h0000, 273, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < 16; i++) ifm_m[i] = '0;
        for (int i = 0; i < 9; i++) wg_m[i] = '0;
        clear_sched();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst wr_err", wr_err, 0);
        chk("rst tmo_err", tmo_err, 0);
        chk("rst eng_start", eng_start, 0);
        chk("rst eng_din", eng_din, 0);
        chk_of("rst", '0);
        chk_weights("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Load buffers; weight index 12 must be ignored
        for (int i = 0; i < 16; i++) begin
            ifm_m[i] = 16'h3C00 + 16'(i);
            wr_if(i, ifm_m[i]);
        end
        for (int i = 0; i < 9; i++) begin
            wg_m[i] = 16'hBC00 + 16'(i);
            wr_wg(i, wg_m[i]);
        end
        wr_wg(12, 16'hDEAD);
        chk_weights("load");

        // go and ifmap write while busy: no restart, write dropped, wr_err set
        load_vec(vt[0]);
        busy_hit_cyc = 5;
        run_tile("busy_hit", 20);
        busy_hit_cyc = -1;
        chk("busy_hit wr_err", wr_err, 1);
        chk("busy_hit tmo_err", tmo_err, 0);

        // Write in the go cycle is performed, unflagged; ifmap[3] still original
        go_wr = 1'b1; gw_addr = 4'd5; gw_data = 16'h5555; ifm_m[5] = 16'h5555;
        load_vec(vt[1]);
        run_tile("go_write", 17);
        go_wr = 1'b0; gw_addr = '0; gw_data = '0;
        chk("go_write wr_err", wr_err, 0);
        chk_weights("busy");

        // Table of engine scenarios
        for (int k = 0; k < 7; k++) begin
            load_vec(vt[k]);
            run_tile($sformatf("vec%0d", k), vt[k].exp_cc);
            chk($sformatf("vec%0d tmo_err", k), tmo_err, vt[k].exp_tmo);
            chk($sformatf("vec%0d wr_err", k), wr_err, 0);
            chk_of($sformatf("vec%0d", k), vt[k].exp_of);
        end

        // Reset at STREAM cycle 5 aborts and clears everything
        clear_sched();
        go = 1'b1;
        @(posedge clk); #1;                // cycle 1, STREAM k=0
        go = 1'b0;
        @(posedge clk); #1;                // cycle 2
        eng_dout_valid = 1'b1; eng_result = 16'h1234;
        @(posedge clk); #1;                // cycle 3
        eng_dout_valid = 1'b0; eng_result = '0;
        of_raddr = 2'd0;
        #1;
        chk("pre-rst of_rdata", of_rdata, 16'h1234);
        repeat (3) @(posedge clk);
        #1;                                // cycle 6, STREAM k=5
        chk("pre-rst eng_din", eng_din, ifm_m[5]);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort eng_start", eng_start, 0);
        chk("abort busy", busy, 0);
        chk("abort of_rdata", of_rdata, 0);
        for (int i = 0; i < 16; i++) ifm_m[i] = '0;
        for (int i = 0; i < 9; i++) wg_m[i] = '0;
        chk_weights("abort");

        // Randomized tiles against the reference model
        for (int i = 0; i < 16; i++) begin
            ifm_m[i] = 16'($urandom);
            wr_if(i, ifm_m[i]);
        end
        for (int i = 0; i < 9; i++) begin
            wg_m[i] = 16'($urandom);
            wr_wg(i, wg_m[i]);
        end
        chk_weights("rand");
        for (int t = 0; t < 12; t++) begin
            clear_sched();
            for (int j = 0; j < int'($urandom_range(0, 7)); j++) begin
                int c = $urandom_range(1, 60);
                s_vld[c] = 1'b1;
                s_val[c] = 16'($urandom);
            end
            if ($urandom_range(0, 7) != 0) s_done[$urandom_range(1, 60)] = 1'b1;
            busy_hit_cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : -1;
            exp_wr = (busy_hit_cyc >= 0);
            model(cc, tmo, of);
            run_tile($sformatf("rand%0d", t), cc);
            busy_hit_cyc = -1;
            chk($sformatf("rand%0d tmo_err", t), tmo_err, tmo);
            chk($sformatf("rand%0d wr_err", t), wr_err, exp_wr);
            chk_of($sformatf("rand%0d", t), of);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
